// File: rtl/grant_arbiter16.sv
// Sixteen-way round-robin grant arbiter with a hold-time limit.
// A grant is held until done, until its own request drops, or until MAX_HOLD cycles have elapsed.
module grant_arbiter16 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  grant_idx_q, grant_idx_d;
    logic        grant_valid_q, grant_valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;

    logic [4:0]  pick_s;
    logic        hold_limit_s;
    logic        req_drop_s;

    // Returns {found, index} of the first set request, searching upward from p.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
        logic       found;
        logic [3:0] idx;
        logic [3:0] k;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            k = p + 4'(i);
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    assign pick_s       = rr_pick(req, ptr_q);
    assign hold_limit_s = (hold_cnt_q == HOLD_LAST);
    assign req_drop_s   = ~req[grant_idx_q];

    // Next-state logic for the arbitration FSM and its registered outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_s[4]) begin
                    grant_idx_d   = pick_s[3:0];
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = 8'd0;
                    state_d       = GRANT;
                end else begin
                    grant_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (done || req_drop_s || hold_limit_s) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_idx_q + 4'd1;
                    state_d       = IDLE;
                    // Only a pure hold-limit expiry counts as a forced revoke.
                    timeout_d     = hold_limit_s && !done && !req_drop_s;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 4'd0;
            grant_idx_q   <= 4'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_grant_arbiter16.sv
// Directed self-checking bench for grant_arbiter16 (MAX_HOLD=4 instance plus a MAX_HOLD=1 instance).
module tb_grant_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    logic [15:0] req1;
    logic        done1;
    logic [3:0]  grant_idx1;
    logic        grant_valid1;
    logic        timeout1;

    int n_checks = 0;
    int n_fail   = 0;

    grant_arbiter16 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    grant_arbiter16 #(.MAX_HOLD(1)) dut_h1 (
        .clk         (clk),
        .rst         (rst),
        .req         (req1),
        .done        (done1),
        .grant_idx   (grant_idx1),
        .grant_valid (grant_valid1),
        .timeout     (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        req   = 16'h0000;
        done  = 1'b0;
        req1  = 16'h0000;
        done1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req   = 16'h0000;
        done  = 1'b0;
        req1  = 16'h0000;
        done1 = 1'b0;
        rst   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({grant_valid, grant_idx, timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b idx=%0d to=%b, expected all 0", grant_valid, grant_idx, timeout);
        end
        tick();
        n_checks++;
        if ({grant_valid, grant_idx, timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_held: got v=%b idx=%0d to=%b, expected all 0", grant_valid, grant_idx, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_quiet;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({grant_valid, grant_idx, timeout} !== 6'b0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: got v=%b idx=%0d to=%b, expected all 0", i, grant_valid, grant_idx, timeout);
            end
        end
    endtask

    task automatic test_rotate_8001;
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'd0;
        exp_seq[1] = 4'd15;
        exp_seq[2] = 4'd0;
        exp_seq[3] = 4'd15;
        apply_reset();
        req = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rotate_grant[%0d]: got v=%b idx=%0d, expected v=1 idx=%0d", i, grant_valid, grant_idx, exp_seq[i]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_checks++;
            if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rotate_gap[%0d]: got v=%b to=%b, expected v=0 to=0", i, grant_valid, timeout);
            end
        end
        req = 16'h0000;
    endtask

    task automatic test_hold_limit;
        apply_reset();
        req = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'd4 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_valid[%0d]: got v=%b idx=%0d to=%b, expected v=1 idx=4 to=0", i, grant_valid, grant_idx, timeout);
            end
        end
        tick();
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_timeout: got v=%b to=%b, expected v=0 to=1", grant_valid, timeout);
        end
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd4 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_regrant: got v=%b idx=%0d to=%b, expected v=1 idx=4 to=0", grant_valid, grant_idx, timeout);
        end
        // done arriving on the limit edge suppresses the timeout pulse
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_done_prec: got v=%b to=%b, expected v=0 to=0", grant_valid, timeout);
        end
        req = 16'h0000;
        tick();
    endtask

    task automatic test_ptr_wrap;
        apply_reset();
        req = 16'h8000;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_first: got v=%b idx=%0d, expected v=1 idx=15", grant_valid, grant_idx);
        end
        done = 1'b1;
        req  = 16'hFFFF;
        tick();
        done = 1'b0;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_next: got v=%b idx=%0d, expected v=1 idx=0", grant_valid, grant_idx);
        end
        req = 16'h0000;
        tick();
    endtask

    task automatic test_rotate_mid;
        apply_reset();
        req = 16'h0020;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 16'h0021;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL rotate_mid: got v=%b idx=%0d, expected v=1 idx=0", grant_valid, grant_idx);
        end
        // other requesters appearing mid-grant must not disturb it
        req = 16'hFFFF;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL ignore_others: got v=%b idx=%0d, expected v=1 idx=0", grant_valid, grant_idx);
        end
        req = 16'h0000;
        tick();
    endtask

    task automatic test_req_drop_and_reset;
        apply_reset();
        req = 16'h0008;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL drop_grant: got v=%b idx=%0d, expected v=1 idx=3", grant_valid, grant_idx);
        end
        req = 16'h0000;
        tick();
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: got v=%b to=%b, expected v=0 to=0", grant_valid, timeout);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done: got v=%b to=%b, expected v=0 to=0", grant_valid, timeout);
        end
        req = 16'h0011;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd4) begin
            n_fail++;
            $display("FAIL ptr_after_drop: got v=%b idx=%0d, expected v=1 idx=4", grant_valid, grant_idx);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL midgrant_reset: got v=%b idx=%0d to=%b, expected v=0 idx=0 to=0", grant_valid, grant_idx, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_restart: got v=%b idx=%0d to=%b, expected v=1 idx=0 to=0", grant_valid, grant_idx, timeout);
        end
        req = 16'h0000;
        tick();
    endtask

    task automatic test_max_hold1;
        apply_reset();
        req1 = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (grant_valid1 !== 1'b1 || grant_idx1 !== 4'd2 || timeout1 !== 1'b0) begin
                n_fail++;
                $display("FAIL h1_grant[%0d]: got v=%b idx=%0d to=%b, expected v=1 idx=2 to=0", i, grant_valid1, grant_idx1, timeout1);
            end
            tick();
            n_checks++;
            if (grant_valid1 !== 1'b0 || timeout1 !== 1'b1) begin
                n_fail++;
                $display("FAIL h1_gap[%0d]: got v=%b to=%b, expected v=0 to=1", i, grant_valid1, timeout1);
            end
        end
        req1 = 16'h0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_quiet();
        test_rotate_8001();
        test_hold_limit();
        test_ptr_wrap();
        test_rotate_mid();
        test_req_drop_and_reset();
        test_max_hold1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
